// File: rtl/icache_refill_fsm.sv
// -----------------------------------------------------------------------------
// icache_refill_fsm
//
// Instruction-cache line refill controller. On a tag miss it issues one burst
// read to the bus, assembles the returning beats into a line buffer, restarts
// the CPU early with the critical word, and commits the full line with a
// one-cycle write pulse. While idle it also services CACHE maintenance ops
// (IndexInvalid / IndexTag / HitInvalid) by pulsing a line write with the
// appropriate valid bit. Ops take priority over a miss in the same cycle.
//
// Parameters
//   LINE_WORDS : words per line (power of two, 4..16)
//   OFFSET_W   : word-offset width
//   WRAP_FILL  : 1 = critical-word-first wrapping burst, 0 = burst from word 0
//
// Ports
//   clk, resetn                  : clock, synchronous active-low reset
//   cpu_req, cpu_word, hit       : fetch request, word offset, tag lookup hit
//   cacheop_valid/kind/wr_valid  : CACHE op request (kind 1/2/3), IndexTag valid
//   cacheop_ready                : op accepted this cycle (combinational)
//   mem_req, mem_word            : burst request and its first word offset
//   mem_addr_ok                  : bus accepted the request
//   mem_data_ok, mem_rdata       : data beat valid and its data
//   line_data, line_we, line_valid : assembled line, write pulse, valid bit
//   cpu_data_ok, cpu_rdata       : early-restart pulse and critical word
//   busy, state                  : FSM not idle, current FSM state
// -----------------------------------------------------------------------------
module icache_refill_fsm #(
    parameter int LINE_WORDS = 8,
    parameter int OFFSET_W   = $clog2(LINE_WORDS),
    parameter int WRAP_FILL  = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cpu_req,
    input  logic [OFFSET_W-1:0]      cpu_word,
    input  logic                     hit,
    input  logic                     cacheop_valid,
    input  logic [1:0]               cacheop_kind,
    input  logic                     cacheop_wr_valid,
    output logic                     cacheop_ready,
    output logic                     mem_req,
    output logic [OFFSET_W-1:0]      mem_word,
    input  logic                     mem_addr_ok,
    input  logic                     mem_data_ok,
    input  logic [31:0]              mem_rdata,
    output logic [LINE_WORDS*32-1:0] line_data,
    output logic                     line_we,
    output logic                     line_valid,
    output logic                     cpu_data_ok,
    output logic [31:0]              cpu_rdata,
    output logic                     busy,
    output logic [1:0]               state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADDR   = 2'd1,
        S_FILL   = 2'd2,
        S_COMMIT = 2'd3
    } state_e;

    localparam int         CNT_W      = OFFSET_W + 1;
    localparam logic [1:0] OP_NONE    = 2'd0;
    localparam logic [1:0] OP_IDX_TAG = 2'd2;

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [OFFSET_W-1:0]             crit_q, crit_d;
    logic [OFFSET_W-1:0]             mem_word_q, mem_word_d;
    logic [LINE_WORDS-1:0][31:0]     line_q, line_d;
    logic                            line_we_q, line_we_d;
    logic                            line_valid_q, line_valid_d;
    logic                            cpu_data_ok_q, cpu_data_ok_d;
    logic [31:0]                     cpu_rdata_q, cpu_rdata_d;

    logic                            op_take;
    logic [OFFSET_W-1:0]             slot;

    // Ops are only accepted in IDLE; elsewhere they are simply held off.
    assign op_take = (state_q == S_IDLE) && cacheop_valid && (cacheop_kind != OP_NONE);

    // Destination slot of the current beat; the OFFSET_W-bit sum wraps at LINE_WORDS.
    assign slot = mem_word_q + cnt_q[OFFSET_W-1:0];

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        crit_d        = crit_q;
        mem_word_d    = mem_word_q;
        line_d        = line_q;
        line_we_d     = 1'b0;
        line_valid_d  = 1'b0;
        cpu_data_ok_d = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (op_take) begin
                    line_we_d    = 1'b1;
                    // Only IndexTag can write a set valid bit; both invalidates clear it.
                    line_valid_d = (cacheop_kind == OP_IDX_TAG) ? cacheop_wr_valid : 1'b0;
                end else if (cpu_req && !hit) begin
                    state_d    = S_ADDR;
                    cnt_d      = '0;
                    crit_d     = cpu_word;
                    mem_word_d = (WRAP_FILL != 0) ? cpu_word : '0;
                end
            end

            S_ADDR: begin
                if (mem_addr_ok) begin
                    state_d = S_FILL;
                end
            end

            S_FILL: begin
                if (mem_data_ok) begin
                    line_d[slot] = mem_rdata;
                    cnt_d        = cnt_q + CNT_W'(1);
                    if (slot == crit_q) begin
                        cpu_data_ok_d = 1'b1;
                        cpu_rdata_d   = mem_rdata;
                    end
                    if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
                        // Write pulse registers into the COMMIT cycle.
                        state_d      = S_COMMIT;
                        line_we_d    = 1'b1;
                        line_valid_d = 1'b1;
                    end
                end
            end

            S_COMMIT: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            crit_q        <= '0;
            mem_word_q    <= '0;
            // NOTE: the line buffer is an output that must read zero out of
            // reset, so unlike a RAM array it is cleared here.
            line_q        <= '0;
            line_we_q     <= 1'b0;
            line_valid_q  <= 1'b0;
            cpu_data_ok_q <= 1'b0;
            cpu_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            crit_q        <= crit_d;
            mem_word_q    <= mem_word_d;
            line_q        <= line_d;
            line_we_q     <= line_we_d;
            line_valid_q  <= line_valid_d;
            cpu_data_ok_q <= cpu_data_ok_d;
            cpu_rdata_q   <= cpu_rdata_d;
        end
    end

    assign cacheop_ready = op_take;
    assign mem_req       = (state_q == S_ADDR);
    assign mem_word      = mem_word_q;
    assign line_data     = line_q;
    assign line_we       = line_we_q;
    assign line_valid    = line_valid_q;
    assign cpu_data_ok   = cpu_data_ok_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign busy          = (state_q != S_IDLE);
    assign state         = state_q;

endmodule

// File: doc/icache_refill_fsm.md
ICACHE_REFILL_FSM -- requirements
Module: icache_refill_fsm

Interface
REQ-001 The block SHALL have parameter LINE_WORDS, default 8, meaning words per cache line (power of two, 4..16).
REQ-002 The block SHALL have parameter OFFSET_W, default $clog2(LINE_WORDS), meaning word-offset width.
REQ-003 The block SHALL have parameter WRAP_FILL, default 1, meaning 1 = critical-word-first wrapping burst and 0 = sequential burst from word 0.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1, a synchronous active-low reset.
REQ-006 The block SHALL have port cpu_req, input, 1, meaning fetch request valid.
REQ-007 The block SHALL have port cpu_word, input, OFFSET_W, meaning requested word offset within the line.
REQ-008 The block SHALL have port hit, input, 1, meaning tag lookup hit for the current request.
REQ-009 The block SHALL have port cacheop_valid, input, 1, meaning a CACHE instruction request.
REQ-010 The block SHALL have port cacheop_kind, input, 2, encoded 1=IndexInvalid, 2=IndexTag, 3=HitInvalid, 0=none.
REQ-011 The block SHALL have port cacheop_wr_valid, input, 1, meaning the valid bit supplied by IndexTag.
REQ-012 The block SHALL have port cacheop_ready, output, 1, meaning a CACHE op is accepted this cycle.
REQ-013 The block SHALL have port mem_req, output, 1, meaning a burst read request to the bus.
REQ-014 The block SHALL have port mem_word, output, OFFSET_W, meaning the first word offset of the burst.
REQ-015 The block SHALL have port mem_addr_ok, input, 1, meaning the bus accepted the request.
REQ-016 The block SHALL have port mem_data_ok, input, 1, meaning a data beat is valid.
REQ-017 The block SHALL have port mem_rdata, input, 32, meaning the beat data.
REQ-018 The block SHALL have port line_data, output, LINE_WORDS*32, meaning the assembled line with word i at bits [32i+31:32i].
REQ-019 The block SHALL have port line_we, output, 1, a one-cycle pulse writing line, tag and valid.
REQ-020 The block SHALL have port line_valid, output, 1, meaning the valid bit written with line_we.
REQ-021 The block SHALL have port cpu_data_ok, output, 1, an early-restart pulse.
REQ-022 The block SHALL have port cpu_rdata, output, 32, meaning the critical word.
REQ-023 The block SHALL have port busy, output, 1, meaning state != IDLE.
REQ-024 The block SHALL have port state, output, 2, meaning the current FSM state.

Function
REQ-025 The FSM SHALL have states IDLE=0, ADDR=1, FILL=2 and COMMIT=3.
REQ-026 In IDLE, cacheop_valid with kind != 0 SHALL take priority over cpu_req: cacheop_ready=1 combinationally, line_we=1 on the next cycle, and state SHALL stay IDLE.
REQ-027 Op valid bits SHALL be: line_valid=0 for IndexInvalid, cacheop_wr_valid for IndexTag, 0 for HitInvalid.
REQ-028 cacheop_ready SHALL be 0 in every state other than IDLE; ops SHALL be held off there.
REQ-029 In IDLE, cpu_req=1 with hit=1 SHALL leave state unchanged with no outputs asserted.
REQ-030 In IDLE, cpu_req=1 with hit=0 and no op SHALL cause, next cycle: state=ADDR, mem_req=1, mem_word=(WRAP_FILL ? cpu_word : 0), critical offset latched from cpu_word, beat counter=0.
REQ-031 In ADDR, mem_req SHALL be held until mem_addr_ok=1; the next cycle SHALL have state=FILL and mem_req=0; mem_word SHALL be stable while mem_req=1.
REQ-032 mem_data_ok SHALL be ignored outside FILL.
REQ-033 In FILL, each mem_data_ok SHALL write mem_rdata to slot (mem_word + cnt) mod LINE_WORDS, and cnt SHALL increment; cnt is OFFSET_W+1 bits and slot arithmetic wraps at LINE_WORDS.
REQ-034 When the beat written is the critical slot, cpu_data_ok=1 for exactly one cycle on the next cycle, with cpu_rdata equal to that beat.
REQ-035 The LINE_WORDS-th beat SHALL cause state=COMMIT next cycle; cycles without mem_data_ok SHALL hold state and cnt.
REQ-036 COMMIT SHALL assert line_we=1 and line_valid=1 for one cycle with line_data complete, then go to IDLE.
REQ-037 cpu_req deassertion during ADDR/FILL SHALL NOT abort the refill; the line SHALL still commit.
REQ-038 The block SHALL service no new miss before return to IDLE; a request present on the IDLE return cycle SHALL be evaluated against hit normally.

Reset
REQ-039 resetn=0 at a clock edge SHALL force state=IDLE, cnt=0, and mem_req, line_we, line_valid, cpu_data_ok and cpu_rdata to 0, with line_data=0.
REQ-040 Reset mid-ADDR/FILL SHALL discard the partial line, with no line_we or cpu_data_ok afterwards.

Verification
REQ-041 The bench SHALL cover: LINE_WORDS=8, WRAP_FILL=1, miss with cpu_word=5 -> mem_word=5, fill order 5,6,7,0,1,2,3,4; cpu_data_ok after first beat; line_we one cycle after 8th beat.
REQ-042 The bench SHALL cover: WRAP_FILL=0, cpu_word=5 -> mem_word=0; cpu_data_ok after 6th beat with cpu_rdata = beat 6 data.
REQ-043 The bench SHALL cover: mem_addr_ok delayed 3 cycles and mem_data_ok gapped -> mem_req held 3 cycles; line_data word i equals beat for slot i.
REQ-044 The bench SHALL cover: IDLE with cacheop IndexTag, wr_valid=1, plus cpu_req miss the same cycle -> line_we with line_valid=1 next cycle, then the miss starts the following cycle.
REQ-045 The bench SHALL cover: cacheop_valid during FILL -> cacheop_ready=0 until IDLE.
REQ-046 The bench SHALL cover: resetn=0 after 3 beats -> state=0, mem_req=0, no line_we within 20 cycles.
